// File: rtl/store_buffer.sv
`timescale 1ns/1ps
// store_buffer
// FIFO write buffer in front of data_memory in the MEM stage. Stores from
// EX/MEM are queued and retired one per cycle whenever the memory port is
// not needed by a load. Loads that hit a queued store are forwarded the
// youngest matching data so program order is preserved.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   st_valid/addr/data  store request; st_ready = buffer can accept it
//   ld_valid/addr       load request
//   ld_hit/ld_fwd_data  load matched a queued store / youngest matching data
//   ld_stall            load must be held; the port is given to a drain
//   mem_*               data_memory address, write data, write and read strobes
//   count/empty/full    occupancy
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 13,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [DW-1:0]              st_data,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_addr,
    output logic                       ld_hit,
    output logic [DW-1:0]              ld_fwd_data,
    output logic                       ld_stall,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_write_data,
    output logic                       mem_write,
    output logic                       mem_read,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count_q;
    logic [AW-1:0]    ent_addr [DEPTH];
    logic [DW-1:0]    ent_data [DEPTH];
    logic [DEPTH-1:0] ent_valid;

    logic enq;
    logic drain;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign count    = count_q;
    assign st_ready = !full;

    // A full buffer claims the port even under load pressure so it always
    // makes forward progress; otherwise loads take priority.
    assign enq      = st_valid && st_ready;
    assign drain    = !empty && (!ld_valid || full);
    assign ld_stall = ld_valid && full && !empty;

    always_comb begin
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        if (drain) begin
            mem_write      = 1'b1;
            mem_addr       = ent_addr[head];
            mem_write_data = ent_data[head];
        end else if (ld_valid) begin
            mem_read = 1'b1;
            mem_addr = ld_addr;
        end
    end

    // Walk from oldest to youngest so the last match wins; the entry being
    // drained this cycle is still valid and therefore still forwards.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        ld_hit      = 1'b0;
        ld_fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ld_valid && ent_valid[head + PW'(i)] &&
                ent_addr[head + PW'(i)] == ld_addr) begin
                ld_hit      = 1'b1;
                ld_fwd_data = ent_data[head + PW'(i)];
            end
        end
    end

    // Control state: pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            head      <= '0;
            tail      <= '0;
            count_q   <= '0;
            ent_valid <= '0;
        end else begin
            if (enq) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + 1'b1;
            end
            if (drain) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            case ({enq, drain})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: the address/data array is not reset; the valid bits alone decide whether an entry is meaningful.
    always_ff @(posedge clk) begin
        if (enq) begin
            ent_addr[tail] <= st_addr;
            ent_data[tail] <= st_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
`timescale 1ns/1ps
module tb_store_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 13;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          st_valid = 1'b0;
    logic [AW-1:0] st_addr = '0;
    logic [DW-1:0] st_data = '0;
    logic          st_ready;
    logic          ld_valid = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic          ld_hit;
    logic [DW-1:0] ld_fwd_data;
    logic          ld_stall;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_write_data;
    logic          mem_write;
    logic          mem_read;
    logic [2:0]    count;
    logic          empty;
    logic          full;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] wlog_addr [$];
    logic [DW-1:0] wlog_data [$];

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_fwd_data(ld_fwd_data),
        .ld_stall(ld_stall), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    // Memory-side monitor: a write is committed on the rising edge that
    // follows a cycle with mem_write high; sample just before that edge.
    always @(negedge clk) begin
        #4;
        if (mem_write) begin
            wlog_addr.push_back(mem_addr);
            wlog_data.push_back(mem_write_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge; inputs are changed there and
    // outputs are checked 1ns later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wait_empty();
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            cyc();
            settle();
            if (empty) done = 1'b1;
        end
        check("drain_timeout", done, 1);
    endtask

    task automatic clear_log();
        wlog_addr.delete();
        wlog_data.delete();
    endtask

    task automatic check_log(input string tag, input logic [AW-1:0] ea [], input logic [DW-1:0] ed []);
        check({tag, "_nwr"}, wlog_addr.size(), ea.size());
        for (int i = 0; i < ea.size() && i < wlog_addr.size(); i++) begin
            check($sformatf("%s_wa%0d", tag, i), wlog_addr[i], ea[i]);
            check($sformatf("%s_wd%0d", tag, i), wlog_data[i], ed[i]);
        end
    endtask

    initial begin
        logic [AW-1:0] ea [];
        logic [DW-1:0] ed [];

        // ---- reset then idle ----
        repeat (3) begin
            cyc();
            settle();
            check("rst_empty", empty, 1);
            check("rst_full", full, 0);
            check("rst_st_ready", st_ready, 1);
            check("rst_mem_write", mem_write, 0);
            check("rst_mem_read", mem_read, 0);
            check("rst_ld_hit", ld_hit, 0);
            check("rst_ld_stall", ld_stall, 0);
            check("rst_fwd", ld_fwd_data, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_wdata", mem_write_data, 0);
            check("rst_count", count, 0);
        end
        rst_n = 1'b1;
        repeat (10) begin
            cyc();
            settle();
            check("idle_empty", empty, 1);
            check("idle_st_ready", st_ready, 1);
            check("idle_mem_write", mem_write, 0);
        end

        // ---- single store ----
        clear_log();
        cyc();
        st_valid = 1'b1; st_addr = 13'h004; st_data = 32'h12345678;
        settle();
        check("s1_ready", st_ready, 1);
        check("s1_nowr", mem_write, 0);
        cyc();
        st_valid = 1'b0;
        settle();
        check("s1_count", count, 1);
        check("s1_wr", mem_write, 1);
        check("s1_addr", mem_addr, 13'h004);
        check("s1_data", mem_write_data, 32'h12345678);
        cyc();
        settle();
        check("s1_empty", empty, 1);
        check("s1_wr_done", mem_write, 0);
        ld_valid = 1'b1; ld_addr = 13'h004;
        settle();
        check("s1_ld_hit", ld_hit, 0);
        check("s1_ld_rd", mem_read, 1);
        check("s1_ld_addr", mem_addr, 13'h004);
        check("s1_ld_fwd", ld_fwd_data, 0);

        // ---- forwarding order with continuous loads ----
        cyc();
        ld_addr = 13'h010;
        st_valid = 1'b1; st_addr = 13'h010; st_data = 32'hAAAA0000;
        settle();
        check("fw_rd0", mem_read, 1);
        check("fw_hit0", ld_hit, 0);
        cyc();
        st_data = 32'hBBBB0000;
        settle();
        check("fw_hit1", ld_hit, 1);
        check("fw_fwd1", ld_fwd_data, 32'hAAAA0000);
        check("fw_nowr1", mem_write, 0);
        cyc();
        st_valid = 1'b0;
        settle();
        check("fw_count", count, 2);
        check("fw_hit2", ld_hit, 1);
        check("fw_fwd2", ld_fwd_data, 32'hBBBB0000);
        check("fw_nowr2", mem_write, 0);
        check("fw_rd2", mem_read, 1);
        cyc();
        ld_valid = 1'b0;
        settle();
        check("fw_dr0_wr", mem_write, 1);
        check("fw_dr0_data", mem_write_data, 32'hAAAA0000);
        cyc();
        settle();
        check("fw_dr1_wr", mem_write, 1);
        check("fw_dr1_data", mem_write_data, 32'hBBBB0000);
        wait_empty();
        ea = '{13'h004, 13'h010, 13'h010};
        ed = '{32'h12345678, 32'hAAAA0000, 32'hBBBB0000};
        check_log("fw", ea, ed);

        // ---- full under load pressure ----
        clear_log();
        cyc();
        ld_valid = 1'b1; ld_addr = 13'h100;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            st_valid = 1'b1; st_addr = AW'(13'h020 + i); st_data = DW'(32'hC0 + i);
            settle();
            check("fl_fill_nowr", mem_write, 0);
        end
        cyc();
        st_addr = 13'h024; st_data = 32'hC4;
        settle();
        check("fl_count4", count, 4);
        check("fl_full", full, 1);
        check("fl_st_ready", st_ready, 0);
        check("fl_stall", ld_stall, 1);
        check("fl_wr", mem_write, 1);
        check("fl_rd", mem_read, 0);
        check("fl_addr", mem_addr, 13'h020);
        check("fl_data", mem_write_data, 32'hC0);
        cyc();
        settle();
        check("fl_count3", count, 3);
        check("fl_ready_again", st_ready, 1);
        check("fl_nostall", ld_stall, 0);
        check("fl_nowr", mem_write, 0);
        check("fl_rd2", mem_read, 1);
        check("fl_rd_addr", mem_addr, 13'h100);
        cyc();
        st_valid = 1'b0; ld_addr = 13'h021;
        settle();
        check("fl_refull", full, 1);
        check("fl_stall2", ld_stall, 1);
        check("fl_wr2", mem_write, 1);
        check("fl_addr2", mem_addr, 13'h021);
        check("fl_drain_fwd_hit", ld_hit, 1);
        check("fl_drain_fwd", ld_fwd_data, 32'hC1);
        cyc();
        ld_addr = 13'h024;
        settle();
        check("fl_count_after", count, 3);
        check("fl_hit5", ld_hit, 1);
        check("fl_fwd5", ld_fwd_data, 32'hC4);
        cyc();
        ld_valid = 1'b0;
        wait_empty();
        ea = '{13'h020, 13'h021, 13'h022, 13'h023, 13'h024};
        ed = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4};
        check_log("fl", ea, ed);

        // ---- wrap-around: 5 back-to-back, then 5 with idle gaps ----
        clear_log();
        for (int i = 0; i < 5; i++) begin
            cyc();
            st_valid = 1'b1; st_addr = AW'(i); st_data = DW'(32'hD000 + i);
            settle();
            if (i > 0) begin
                check("wr_b2b_count", count, 1);
                check("wr_b2b_wr", mem_write, 1);
            end
        end
        for (int i = 5; i < 10; i++) begin
            cyc();
            st_valid = 1'b1; st_addr = AW'(i); st_data = DW'(32'hD000 + i);
            cyc();
            st_valid = 1'b0;
        end
        wait_empty();
        ea = new[10];
        ed = new[10];
        for (int i = 0; i < 10; i++) begin
            ea[i] = AW'(i);
            ed[i] = DW'(32'hD000 + i);
        end
        check_log("wrap", ea, ed);

        // ---- async reset mid-operation ----
        clear_log();
        cyc();
        ld_valid = 1'b1; ld_addr = 13'h200;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) cyc();
            st_valid = 1'b1; st_addr = AW'(13'h030 + i); st_data = DW'(32'hE0 + i);
        end
        cyc();
        st_valid = 1'b0;
        settle();
        check("ar_count3", count, 3);
        check("ar_nowr", mem_write, 0);
        #2;
        rst_n = 1'b0; ld_valid = 1'b0;
        settle();
        check("ar_count0", count, 0);
        check("ar_empty", empty, 1);
        check("ar_full", full, 0);
        check("ar_wr", mem_write, 0);
        check("ar_mem_addr", mem_addr, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        repeat (5) begin
            cyc();
            settle();
            check("ar_post_wr", mem_write, 0);
        end
        check("ar_log", wlog_addr.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
